// File: rtl/rom_port_arbiter.sv
// Shares one synchronous ROM/RAM port between a download writer and three CPU readers.
// Buffered download writes take priority; reads are granted round-robin, one in flight.
module rom_port_arbiter #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 8
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            dn_active,
    input  logic            dn_wr,
    input  logic [AW-1:0]   dn_addr,
    input  logic [DW-1:0]   dn_data,
    input  logic [2:0]      rd_req,
    input  logic [3*AW-1:0] rd_addr,
    output logic [2:0]      rd_ack,
    output logic [DW-1:0]   rd_data,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            dl_busy,
    output logic            dl_overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            grant;

    logic            wbuf_valid;
    logic [AW-1:0]   wbuf_addr;
    logic [DW-1:0]   wbuf_data;
    logic            dn_active_q;

    logic [1:0]      last_grant;
    logic [1:0]      rd_idx;
    logic [2:0]      eligible;
    logic [1:0]      cand0;
    logic [1:0]      cand1;
    logic [1:0]      cand2;
    logic            grant_valid;
    logic [1:0]      grant_idx;

    logic [AW-1:0]   req_addr [3];

    logic            wr_accept;
    logic            wr_drain;
    logic            wr_drop;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : 2'(i + 2'd1);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_unpack
        assign req_addr[g] = rd_addr[g*AW +: AW];
    end

    assign wr_accept = dn_wr & dn_active;
    assign wr_drain  = (state_q == WRITE);
    assign wr_drop   = wr_accept & wbuf_valid & ~wr_drain;
    assign dl_busy   = dn_active | wbuf_valid | wr_drain;

    // Round-robin pick starting after the last granted requester.
    always_comb begin
        eligible    = rd_req & ~rd_ack;
        cand0       = next_idx(last_grant);
        cand1       = next_idx(cand0);
        cand2       = next_idx(cand1);
        grant_valid = 1'b0;
        grant_idx   = cand0;
        if (eligible[cand0]) begin
            grant_valid = 1'b1;
            grant_idx   = cand0;
        end else if (eligible[cand1]) begin
            grant_valid = 1'b1;
            grant_idx   = cand1;
        end else if (eligible[cand2]) begin
            grant_valid = 1'b1;
            grant_idx   = cand2;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wbuf_valid) begin
                    state_d = WRITE;
                end else if (!dn_active && grant_valid) begin
                    state_d = RD_ISSUE;
                    grant   = 1'b1;
                end
            end
            WRITE:    state_d = IDLE;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write buffer and overflow flag; a write landing on the drain cycle refills the buffer.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wbuf_valid  <= 1'b0;
            wbuf_addr   <= '0;
            wbuf_data   <= '0;
            dn_active_q <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            dn_active_q <= dn_active;
            if (wr_accept && (!wbuf_valid || wr_drain)) begin
                wbuf_valid <= 1'b1;
                wbuf_addr  <= dn_addr;
                wbuf_data  <= dn_data;
            end else if (wr_drain) begin
                wbuf_valid <= 1'b0;
            end
            if (wr_drop) begin
                dl_overflow <= 1'b1;
            end else if (dn_active && !dn_active_q) begin
                dl_overflow <= 1'b0;
            end
        end
    end

    // Memory port drive, grant bookkeeping and read return.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= 2'd2;
            rd_idx     <= 2'd0;
            rd_ack     <= 3'b000;
            rd_data    <= '0;
        end else begin
            mem_we <= (state_d == WRITE);
            if (state_q == IDLE && state_d == WRITE) begin
                mem_addr  <= wbuf_addr;
                mem_wdata <= wbuf_data;
            end else if (grant) begin
                mem_addr   <= req_addr[grant_idx];
                last_grant <= grant_idx;
                rd_idx     <= grant_idx;
            end
            rd_ack <= 3'b000;
            if (state_q == RD_WAIT) begin
                rd_ack[rd_idx] <= 1'b1;
                rd_data        <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a synchronous memory model.
module tb_rom_port_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic            dn_active;
    logic            dn_wr;
    logic [AW-1:0]   dn_addr;
    logic [DW-1:0]   dn_data;
    logic [2:0]      rd_req;
    logic [3*AW-1:0] rd_addr;
    logic [2:0]      rd_ack;
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            dl_busy;
    logic            dl_overflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    rom_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .dn_active   (dn_active),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .dl_busy     (dl_busy),
        .dl_overflow (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic set_rd_addr(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dn_active = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        rd_req = 3'b000; rd_addr = '0;
        repeat (3) tick();
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL reset_rd_ack got %b exp 000", rd_ack); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 17'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h exp 00", mem_wdata); end
        checks++; if (dl_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", dl_overflow); end
        checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", dl_busy); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_next;
        int last_cyc;
        int nacks;
        logic [2:0] exp_ack;
        logic [AW-1:0] addrs [3];
        addrs[0] = 17'h01111; addrs[1] = 17'h02222; addrs[2] = 17'h03333;
        apply_reset();
        for (int i = 0; i < 3; i++) set_rd_addr(i, addrs[i]);
        rd_req = 3'b111;
        exp_next = 0; last_cyc = -1; nacks = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (rd_ack !== 3'b000) begin
                exp_ack = 3'(1 << exp_next);
                checks++;
                if (rd_ack !== exp_ack) begin errors++; $display("FAIL rr_order got %b exp %b", rd_ack, exp_ack); end
                checks++;
                if (rd_data !== pat(addrs[exp_next])) begin
                    errors++; $display("FAIL rr_data got %h exp %h", rd_data, pat(addrs[exp_next]));
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc > 4) begin errors++; $display("FAIL rr_gap got %0d exp <=4", cyc - last_cyc); end
                end
                last_cyc = cyc;
                exp_next = (exp_next + 1) % 3;
                nacks++;
            end
        end
        checks++; if (nacks < 9) begin errors++; $display("FAIL rr_count got %0d exp >=9", nacks); end
        rd_req = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_single_read();
        set_rd_addr(0, 17'h00123);
        rd_req = 3'b001;
        tick();
        checks++; if (mem_addr !== 17'h00123) begin errors++; $display("FAIL single_mem_addr got %h exp 00123", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_mem_we got %b exp 0", mem_we); end
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL single_early_ack1 got %b exp 000", rd_ack); end
        tick();
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL single_early_ack2 got %b exp 000", rd_ack); end
        tick();
        checks++; if (rd_ack !== 3'b001) begin errors++; $display("FAIL single_ack got %b exp 001", rd_ack); end
        checks++; if (rd_data !== pat(17'h00123)) begin errors++; $display("FAIL single_data got %h exp %h", rd_data, pat(17'h00123)); end
        rd_req = 3'b000;
        tick();
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse got %b exp 000", rd_ack); end
        checks++; if (rd_data !== pat(17'h00123)) begin errors++; $display("FAIL single_hold got %h exp %h", rd_data, pat(17'h00123)); end
        repeat (2) tick();
    endtask

    task automatic test_download();
        int nwe;
        int nack;
        rd_req = 3'b111;
        dn_active = 1'b1;
        nwe = 0; nack = 0;
        for (int c = 0; c < 520; c++) begin
            tick();
            if (mem_we === 1'b1) begin
                checks++;
                if (mem_addr !== 17'(nwe) || mem_wdata !== (8'(nwe) ^ 8'hC3)) begin
                    errors++;
                    $display("FAIL dl_write got %h/%h exp %h/%h", mem_addr, mem_wdata, 17'(nwe), 8'(nwe) ^ 8'hC3);
                end
                nwe++;
            end
            if (rd_ack !== 3'b000) nack++;
            if (c % 2 == 0 && c < 512) begin
                dn_wr = 1'b1; dn_addr = 17'(c / 2); dn_data = 8'(c / 2) ^ 8'hC3;
            end else begin
                dn_wr = 1'b0;
            end
        end
        checks++; if (nwe !== 256) begin errors++; $display("FAIL dl_count got %0d exp 256", nwe); end
        checks++; if (nack !== 0) begin errors++; $display("FAIL dl_no_ack got %0d exp 0", nack); end
        checks++; if (dl_overflow !== 1'b0) begin errors++; $display("FAIL dl_overflow got %b exp 0", dl_overflow); end
        checks++; if (dl_busy !== 1'b1) begin errors++; $display("FAIL dl_busy_active got %b exp 1", dl_busy); end
        rd_req = 3'b000;
        dn_active = 1'b0;
        repeat (2) tick();
        checks++; if (dl_busy !== 1'b0) begin errors++; $display("FAIL dl_busy_idle got %b exp 0", dl_busy); end
    endtask

    task automatic test_overflow();
        set_rd_addr(0, 17'h04567);
        rd_req = 3'b001;
        tick();
        dn_active = 1'b1;
        tick();
        dn_wr = 1'b1; dn_addr = 17'h01000; dn_data = 8'hAA;
        tick();
        checks++; if (rd_ack !== 3'b001) begin errors++; $display("FAIL ovf_ack got %b exp 001", rd_ack); end
        checks++; if (rd_data !== pat(17'h04567)) begin errors++; $display("FAIL ovf_rdata got %h exp %h", rd_data, pat(17'h04567)); end
        dn_wr = 1'b1; dn_addr = 17'h01001; dn_data = 8'hBB;
        rd_req = 3'b000;
        tick();
        dn_wr = 1'b0;
        checks++; if (dl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", dl_overflow); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ovf_we got %b exp 1", mem_we); end
        checks++; if (mem_addr !== 17'h01000) begin errors++; $display("FAIL ovf_waddr got %h exp 01000", mem_addr); end
        checks++; if (mem_wdata !== 8'hAA) begin errors++; $display("FAIL ovf_wdata got %h exp aa", mem_wdata); end
        tick();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ovf_dropped_we got %b exp 0", mem_we); end
        dn_active = 1'b0;
        tick();
        checks++; if (dl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", dl_overflow); end
        dn_active = 1'b1;
        tick();
        checks++; if (dl_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", dl_overflow); end
        dn_active = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_dn_during_issue();
        int nwe;
        int nack;
        set_rd_addr(1, 17'h05555);
        rd_req = 3'b010;
        tick();
        checks++; if (mem_addr !== 17'h05555) begin errors++; $display("FAIL iss_mem_addr got %h exp 05555", mem_addr); end
        dn_active = 1'b1;
        rd_req = 3'b111;
        tick();
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL iss_early_ack got %b exp 000", rd_ack); end
        dn_wr = 1'b1; dn_addr = 17'h01100; dn_data = 8'h77;
        tick();
        dn_wr = 1'b0;
        checks++; if (rd_ack !== 3'b010) begin errors++; $display("FAIL iss_ack got %b exp 010", rd_ack); end
        checks++; if (rd_data !== pat(17'h05555)) begin errors++; $display("FAIL iss_data got %h exp %h", rd_data, pat(17'h05555)); end
        nwe = 0; nack = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (mem_we === 1'b1) nwe++;
            if (rd_ack !== 3'b000) nack++;
        end
        checks++; if (nwe !== 1) begin errors++; $display("FAIL iss_writes got %0d exp 1", nwe); end
        checks++; if (nack !== 0) begin errors++; $display("FAIL iss_no_ack got %0d exp 0", nack); end
        rd_req = 3'b000;
        dn_active = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        set_rd_addr(1, 17'h06789);
        set_rd_addr(0, 17'h01111);
        rd_req = 3'b010;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (mem_addr !== 17'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL rst_ack got %b exp 000", rd_ack); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", rd_data); end
        rd_req = 3'b111;
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rd_ack !== 3'b000 && !seen) begin
                seen = 1'b1;
                checks++; if (rd_ack !== 3'b001) begin errors++; $display("FAIL rst_first_grant got %b exp 001", rd_ack); end
                checks++; if (k !== 2) begin errors++; $display("FAIL rst_latency got %0d exp 2", k); end
                checks++; if (rd_data !== pat(17'h01111)) begin errors++; $display("FAIL rst_data got %h exp %h", rd_data, pat(17'h01111)); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_ack_seen got 0 exp 1"); end
        rd_req = 3'b000;
        repeat (5) tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = pat(17'(a));
        test_reset();
        test_round_robin();
        test_single_read();
        test_download();
        test_overflow();
        test_dn_during_issue();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
